// File: rtl/multi_pattern_generator.sv
// Registered video test-pattern source: SMPTE bars, ramp, checker, solid.
// Ports: clk/rstn, i_hcount/i_vcount, i_mode, i_solid_rgb, i_scroll_en in; o_red/o_grn/o_blu, o_de, o_mode out.
module multi_pattern_generator #(
  parameter int HMAX        = 800,
  parameter int VMAX        = 600,
  parameter int HA          = 640,
  parameter int VA          = 480,
  parameter int CW          = 8,
  parameter int CHK_LOG2    = 5,
  parameter int SCROLL_STEP = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [$clog2(HMAX)-1:0]  i_hcount,
  input  logic [$clog2(VMAX)-1:0]  i_vcount,
  input  logic [1:0]               i_mode,
  input  logic [3*CW-1:0]          i_solid_rgb,
  input  logic                     i_scroll_en,
  output logic [CW-1:0]            o_red,
  output logic [CW-1:0]            o_grn,
  output logic [CW-1:0]            o_blu,
  output logic                     o_de,
  output logic [1:0]               o_mode
);

  localparam int HW   = $clog2(HMAX);
  localparam int VW   = $clog2(VMAX);
  localparam int VTOP = VA * 67 / 100;
  localparam int VMID = VTOP + VA * 8 / 100;
  localparam int HX   = HA / 7;
  localparam int HY   = HA * 5 / 28;
  localparam int HS   = HA / 21;

  localparam logic [HW:0] HA_W = (HW+1)'(HA);
  localparam logic [HW:0] STEP = (HW+1)'(SCROLL_STEP);

  localparam logic [HW:0] C1 = (HW+1)'(HX);
  localparam logic [HW:0] C2 = (HW+1)'(2*HX);
  localparam logic [HW:0] C3 = (HW+1)'(3*HX);
  localparam logic [HW:0] C4 = (HW+1)'(4*HX);
  localparam logic [HW:0] C5 = (HW+1)'(5*HX);
  localparam logic [HW:0] C6 = (HW+1)'(6*HX);

  // PLUGE region: four HS-wide segments after the +Q block,
  // remainder of the line is black.
  localparam logic [HW:0] B1 = (HW+1)'(HY);
  localparam logic [HW:0] B2 = (HW+1)'(2*HY);
  localparam logic [HW:0] B3 = (HW+1)'(3*HY);
  localparam logic [HW:0] B4 = (HW+1)'(3*HY + HS);
  localparam logic [HW:0] B5 = (HW+1)'(3*HY + 2*HS);
  localparam logic [HW:0] B6 = (HW+1)'(3*HY + 3*HS);
  localparam logic [HW:0] B7 = (HW+1)'(3*HY + 4*HS);

  localparam logic [23:0] TOP_C [8] = '{
    24'h686868, 24'hB4B410, 24'h10B4B4, 24'h10B410,
    24'hB410B4, 24'hB41010, 24'h1010B4, 24'h1010B4};
  localparam logic [23:0] MID_C [8] = '{
    24'h1010B4, 24'h101010, 24'hB410B4, 24'h101010,
    24'h10B4B4, 24'h101010, 24'h686868, 24'h686868};
  localparam logic [23:0] BOT_C [8] = '{
    24'h10466A, 24'hEBEBEB, 24'h481076, 24'h101010,
    24'h1A1A1A, 24'h101010, 24'h060606, 24'h101010};

  function automatic logic [CW-1:0] sc(input logic [7:0] c);
    logic [CW-1:0] t;
    t = CW'(c);
    return t << (CW - 8);
  endfunction

  logic [HW-1:0] offset;
  logic          fs;
  logic          active;
  logic [HW:0]   off_sum;
  logic [HW:0]   off_wrap;
  logic [HW-1:0] off_use;
  logic [HW:0]   x_sum;
  logic [HW:0]   xe;
  logic [1:0]    mode_use;
  logic [2:0]    col;
  logic [2:0]    seg;
  logic [23:0]   bar;
  logic [CW-1:0] ramp;
  logic          chk;
  logic [CW-1:0] pr, pg, pb;

  assign fs     = (i_hcount == '0) && (i_vcount == '0);
  assign active = (i_hcount < HW'(HA)) && (i_vcount < VW'(VA));

  // The new mode and scroll offset both apply to the frame-start pixel itself.
  assign mode_use = fs ? i_mode : o_mode;
  assign off_sum  = {1'b0, offset} + STEP;
  assign off_wrap = (off_sum >= HA_W) ? off_sum - HA_W : off_sum;
  assign off_use  = (fs && i_scroll_en) ? off_wrap[HW-1:0] : offset;

  assign x_sum = {1'b0, i_hcount} + {1'b0, off_use};
  assign xe    = (x_sum >= HA_W) ? x_sum - HA_W : x_sum;

  always_comb begin
    col = 3'd6;
    if      (xe < C1) col = 3'd0;
    else if (xe < C2) col = 3'd1;
    else if (xe < C3) col = 3'd2;
    else if (xe < C4) col = 3'd3;
    else if (xe < C5) col = 3'd4;
    else if (xe < C6) col = 3'd5;
  end

  always_comb begin
    seg = 3'd7;
    if      (xe < B1) seg = 3'd0;
    else if (xe < B2) seg = 3'd1;
    else if (xe < B3) seg = 3'd2;
    else if (xe < B4) seg = 3'd3;
    else if (xe < B5) seg = 3'd4;
    else if (xe < B6) seg = 3'd5;
    else if (xe < B7) seg = 3'd6;
  end

  always_comb begin
    bar = BOT_C[seg];
    if (i_vcount < VW'(VTOP))      bar = TOP_C[col];
    else if (i_vcount < VW'(VMID)) bar = MID_C[col];
  end

  assign ramp = CW'(xe);
  assign chk  = xe[CHK_LOG2] ^ i_vcount[CHK_LOG2];

  always_comb begin
    pr = '0;
    pg = '0;
    pb = '0;
    unique case (mode_use)
      2'd0: begin
        pr = sc(bar[23:16]);
        pg = sc(bar[15:8]);
        pb = sc(bar[7:0]);
      end
      2'd1: begin
        pr = ramp;
        pg = ramp;
        pb = ramp;
      end
      2'd2: begin
        pr = {CW{chk}};
        pg = {CW{chk}};
        pb = {CW{chk}};
      end
      default: begin
        pr = i_solid_rgb[3*CW-1:2*CW];
        pg = i_solid_rgb[2*CW-1:CW];
        pb = i_solid_rgb[CW-1:0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_red  <= '0;
      o_grn  <= '0;
      o_blu  <= '0;
      o_de   <= 1'b0;
      o_mode <= 2'd0;
      offset <= '0;
    end else begin
      if (fs) o_mode <= i_mode;
      offset <= off_use;
      o_de   <= active;
      o_red  <= active ? pr : '0;
      o_grn  <= active ? pg : '0;
      o_blu  <= active ? pb : '0;
    end
  end

endmodule

// File: tb/tb_multi_pattern_generator.sv
// Bench for multi_pattern_generator: vector table through a scoreboard,
// plus reset-mid-frame and multi-frame scroll sequences.
module tb_multi_pattern_generator;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  hc, vc;
  logic [1:0]  md;
  logic [23:0] solid;
  logic        se;

  logic [7:0]  r8, g8, b8;
  logic        de8;
  logic [1:0]  m8;
  logic [9:0]  r10, g10, b10;
  logic        de10;
  logic [1:0]  m10;

  always #5 clk = ~clk;

  multi_pattern_generator u8 (
    .clk(clk), .rstn(rstn), .i_hcount(hc), .i_vcount(vc),
    .i_mode(md), .i_solid_rgb(solid), .i_scroll_en(se),
    .o_red(r8), .o_grn(g8), .o_blu(b8), .o_de(de8), .o_mode(m8));

  multi_pattern_generator #(.CW(10)) u10 (
    .clk(clk), .rstn(rstn), .i_hcount(hc), .i_vcount(vc),
    .i_mode(md),
    .i_solid_rgb({solid[23:16], 2'b0, solid[15:8], 2'b0, solid[7:0], 2'b0}),
    .i_scroll_en(se),
    .o_red(r10), .o_grn(g10), .o_blu(b10), .o_de(de10), .o_mode(m10));

  typedef struct {
    int          id;
    logic [7:0]  r, g, b;
    logic        de;
    logic [1:0]  md;
    logic        c10;
    logic [9:0]  y10;
  } exp_t;

  typedef struct {
    int          h, v;
    logic [1:0]  m;
    logic [23:0] s;
    logic [23:0] rgb;
    logic        de;
    logic [1:0]  md;
    logic        c10;
    logic [9:0]  y10;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic apply(input int id, input logic rs, input int h, input int v,
                       input logic [1:0] m, input logic s_en,
                       input logic [23:0] s, input logic [23:0] rgb,
                       input logic de, input logic [1:0] emd,
                       input logic c10, input logic [9:0] y10);
    exp_t e, got;
    logic bad;
    @(negedge clk);
    rstn  = rs;
    hc    = h[9:0];
    vc    = v[9:0];
    md    = m;
    se    = s_en;
    solid = s;
    e = '{id, rgb[23:16], rgb[15:8], rgb[7:0], de, emd, c10, y10};
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL vec%0d scoreboard empty", id);
    end else begin
      got = sb.pop_front();
      bad = (r8 != got.r) || (g8 != got.g) || (b8 != got.b) ||
            (de8 != got.de) || (m8 != got.md);
      if (got.c10)
        bad = bad || (r10 != got.y10) || (g10 != got.y10) || (b10 != got.y10);
      if (bad) begin
        n_miss++;
        $display("FAIL vec%0d: got rgb=%02h%02h%02h de=%0b mode=%0d y10=%0d, expected rgb=%02h%02h%02h de=%0b mode=%0d y10=%0d",
                 got.id, r8, g8, b8, de8, m8, r10,
                 got.r, got.g, got.b, got.de, got.md, got.y10);
      end
    end
  endtask

  initial begin
    int off;
    logic [23:0] v8;
    rstn = 1'b0; hc = '0; vc = '0; md = 2'd2; se = 1'b0; solid = '0;

    // reset state
    apply(1000, 1'b0, 0, 0, 2'd2, 1'b1, 24'h0, 24'h0, 1'b0, 2'd0, 1'b0, 10'd0);
    apply(1001, 1'b0, 5, 5, 2'd3, 1'b0, 24'hFFFFFF, 24'h0, 1'b0, 2'd0, 1'b0, 10'd0);

    //        h    v    m  solid      expected rgb de md c10 y10
    tbl.push_back('{0,   0,   2'd0, 24'h0, 24'h686868, 1'b1, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{91,  0,   2'd0, 24'h0, 24'hB4B410, 1'b1, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{0,   321, 2'd0, 24'h0, 24'h1010B4, 1'b1, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{342, 400, 2'd0, 24'h0, 24'h101010, 1'b1, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{372, 400, 2'd0, 24'h0, 24'h1A1A1A, 1'b1, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{432, 400, 2'd0, 24'h0, 24'h060606, 1'b1, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{0,   400, 2'd0, 24'h0, 24'h10466A, 1'b1, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{114, 400, 2'd0, 24'h0, 24'hEBEBEB, 1'b1, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{228, 400, 2'd0, 24'h0, 24'h481076, 1'b1, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{546, 0,   2'd0, 24'h0, 24'h1010B4, 1'b1, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{545, 0,   2'd0, 24'h0, 24'hB41010, 1'b1, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{90,  320, 2'd0, 24'h0, 24'h686868, 1'b1, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{546, 340, 2'd0, 24'h0, 24'h686868, 1'b1, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{640, 0,   2'd0, 24'h0, 24'h000000, 1'b0, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{0,   480, 2'd0, 24'h0, 24'h000000, 1'b0, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{799, 599, 2'd0, 24'h0, 24'h000000, 1'b0, 2'd0, 1'b0, 10'd0});
    // mode request mid-frame is ignored
    tbl.push_back('{100, 200, 2'd1, 24'h0, 24'hB4B410, 1'b1, 2'd0, 1'b0, 10'd0});
    tbl.push_back('{0,   0,   2'd1, 24'h0, 24'h000000, 1'b1, 2'd1, 1'b1, 10'd0});
    tbl.push_back('{10,  5,   2'd1, 24'h0, 24'h0A0A0A, 1'b1, 2'd1, 1'b1, 10'd10});
    tbl.push_back('{300, 5,   2'd1, 24'h0, 24'h2C2C2C, 1'b1, 2'd1, 1'b1, 10'd300});
    tbl.push_back('{0,   0,   2'd2, 24'h0, 24'h000000, 1'b1, 2'd2, 1'b0, 10'd0});
    tbl.push_back('{32,  0,   2'd2, 24'h0, 24'hFFFFFF, 1'b1, 2'd2, 1'b0, 10'd0});
    tbl.push_back('{32,  32,  2'd2, 24'h0, 24'h000000, 1'b1, 2'd2, 1'b0, 10'd0});
    tbl.push_back('{0,   32,  2'd2, 24'h0, 24'hFFFFFF, 1'b1, 2'd2, 1'b0, 10'd0});
    tbl.push_back('{0,   0,   2'd3, 24'h123456, 24'h123456, 1'b1, 2'd3, 1'b0, 10'd0});
    tbl.push_back('{5,   7,   2'd0, 24'h123456, 24'h123456, 1'b1, 2'd3, 1'b0, 10'd0});
    tbl.push_back('{6,   7,   2'd0, 24'hABCDEF, 24'hABCDEF, 1'b1, 2'd3, 1'b0, 10'd0});
    tbl.push_back('{700, 7,   2'd0, 24'hABCDEF, 24'h000000, 1'b0, 2'd3, 1'b0, 10'd0});

    foreach (tbl[i])
      apply(i, 1'b1, tbl[i].h, tbl[i].v, tbl[i].m, 1'b0, tbl[i].s,
            tbl[i].rgb, tbl[i].de, tbl[i].md, tbl[i].c10, tbl[i].y10);

    // reset mid-frame, then mode stays 0 until next frame start
    apply(2000, 1'b0, 5, 7, 2'd3, 1'b0, 24'h123456, 24'h0, 1'b0, 2'd0, 1'b0, 10'd0);
    apply(2001, 1'b1, 6, 7, 2'd3, 1'b0, 24'h123456, 24'h686868, 1'b1, 2'd0, 1'b0, 10'd0);

    // per-frame scroll in ramp mode
    off = 0;
    for (int k = 1; k <= 161; k++) begin
      off = (off + 4) % 640;
      v8 = {3{off[7:0]}};
      apply(3000 + k, 1'b1, 0, 0, 2'd1, 1'b1, 24'h0, v8, 1'b1, 2'd1, 1'b1, off[9:0]);
      if (k == 159)
        apply(4000, 1'b1, 10, 1, 2'd1, 1'b1, 24'h0, 24'h060606, 1'b1, 2'd1, 1'b1, 10'd6);
    end
    // scroll disabled: offset holds
    apply(4001, 1'b1, 0, 0, 2'd1, 1'b0, 24'h0, 24'h040404, 1'b1, 2'd1, 1'b1, 10'd4);
    apply(4002, 1'b1, 10, 3, 2'd1, 1'b0, 24'h0, 24'h0E0E0E, 1'b1, 2'd1, 1'b1, 10'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
